// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the KCPU stack push/pull sequencers:
// postbyte bit positions, sequencer state encoding and mask helpers.
package jtkcpu_pkg;

    localparam int PB_CC = 0;
    localparam int PB_A  = 1;
    localparam int PB_B  = 2;
    localparam int PB_DP = 3;
    localparam int PB_X  = 4;
    localparam int PB_Y  = 5;
    localparam int PB_SP = 6;
    localparam int PB_PC = 7;

    // Entire-state flag inside the condition code register
    localparam int CC_E = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RDHI = 2'd1,
        ST_RDLO = 2'd2,
        ST_DONE = 2'd3
    } pulseq_state_e;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    function automatic logic [7:0] lsb8(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/jtkcpu_pulsel.sv
// Priority encoder over a push/pull mask: one-hot select of the next register
// (lowest set bit, or highest when REVERSE) and whether that register is 16-bit.
module jtkcpu_pulsel
    import jtkcpu_pkg::*;
#(
    parameter bit REVERSE = 1'b0
) (
    input  logic [7:0] mask,
    output logic [7:0] sel,
    output logic       is16
);

    // Bit 4 upward (X, Y, U/S, PC) are the 16-bit registers
    always_comb begin
        if (REVERSE) begin
            sel = rev8(lsb8(rev8(mask)));
        end else begin
            sel = lsb8(mask);
        end
        is16 = |sel[7:PB_X];
    end

endmodule

// File: rtl/jtkcpu_pulseq.sv
// Stack pull sequencer: walks S or U upward one byte per memory cycle,
// reassembles register values, strobes them out and reports the final pointer.
module jtkcpu_pulseq
    import jtkcpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  postbyte,
    input  logic        us_sel,
    input  logic        rti,
    input  logic [15:0] sp_in,
    output logic [15:0] addr,
    output logic        rd,
    input  logic [7:0]  din,
    input  logic        mem_ok,
    output logic        busy,
    output logic [15:0] data,
    output logic        up_cc,
    output logic        up_a,
    output logic        up_b,
    output logic        up_dp,
    output logic        up_x,
    output logic        up_y,
    output logic        up_u,
    output logic        up_s,
    output logic        up_pc,
    output logic [15:0] nx_sp,
    output logic        up_sp,
    output logic        done
);

    pulseq_state_e state_r;
    logic [7:0]    mask_r;
    logic [15:0]   sp_r;
    logic          us_r;
    logic          rti_r;
    logic [7:0]    hi_r;

    logic [7:0]    start_mask_s;
    logic [7:0]    cur_sel_s;
    logic          cur_is16_s;
    logic [7:0]    clr_mask_s;
    logic [7:0]    nxt_mask_s;
    logic [7:0]    nxt_sel_s;
    logic          nxt_is16_s;
    logic          nxt_any_s;
    logic [15:0]   sp_inc_s;

    assign start_mask_s = rti ? 8'h01 : postbyte;
    assign sp_inc_s     = sp_r + 16'd1;
    assign nxt_mask_s   = (state_r == ST_IDLE) ? start_mask_s : clr_mask_s;
    assign nxt_any_s    = |nxt_sel_s;

    jtkcpu_pulsel u_cur (
        .mask (mask_r),
        .sel  (cur_sel_s),
        .is16 (cur_is16_s)
    );

    jtkcpu_pulsel u_nxt (
        .mask (nxt_mask_s),
        .sel  (nxt_sel_s),
        .is16 (nxt_is16_s)
    );

    // Mask left after the current register completes; RTI chooses the rest from E
    always_comb begin
        if (rti_r && cur_sel_s[PB_CC]) begin
            clr_mask_s = din[CC_E] ? 8'hFE : 8'h80;
        end else begin
            clr_mask_s = mask_r & ~cur_sel_s;
        end
    end

    // Sequencer: start capture, byte walk, register strobes and completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            mask_r  <= 8'h00;
            sp_r    <= 16'h0000;
            us_r    <= 1'b0;
            rti_r   <= 1'b0;
            hi_r    <= 8'h00;
            addr    <= 16'h0000;
            rd      <= 1'b0;
            busy    <= 1'b0;
            data    <= 16'h0000;
            up_cc   <= 1'b0;
            up_a    <= 1'b0;
            up_b    <= 1'b0;
            up_dp   <= 1'b0;
            up_x    <= 1'b0;
            up_y    <= 1'b0;
            up_u    <= 1'b0;
            up_s    <= 1'b0;
            up_pc   <= 1'b0;
            nx_sp   <= 16'h0000;
            up_sp   <= 1'b0;
            done    <= 1'b0;
        end else begin
            {up_cc, up_a, up_b, up_dp, up_x, up_y, up_u, up_s, up_pc} <= 9'h000;
            up_sp <= 1'b0;
            done  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mask_r <= start_mask_s;
                        sp_r   <= sp_in;
                        us_r   <= us_sel;
                        rti_r  <= rti;
                        busy   <= 1'b1;
                        if (nxt_any_s) begin
                            state_r <= nxt_is16_s ? ST_RDHI : ST_RDLO;
                            rd      <= 1'b1;
                            addr    <= sp_in;
                        end else begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            up_sp   <= 1'b1;
                            nx_sp   <= sp_in;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RDHI: begin
                    if (mem_ok) begin
                        hi_r    <= din;
                        sp_r    <= sp_inc_s;
                        addr    <= sp_inc_s;
                        state_r <= ST_RDLO;
                    end
                end
                ST_RDLO: begin
                    if (mem_ok) begin
                        sp_r   <= sp_inc_s;
                        mask_r <= clr_mask_s;
                        data   <= cur_is16_s ? {hi_r, din} : {8'h00, din};
                        up_cc  <= cur_sel_s[PB_CC];
                        up_a   <= cur_sel_s[PB_A];
                        up_b   <= cur_sel_s[PB_B];
                        up_dp  <= cur_sel_s[PB_DP];
                        up_x   <= cur_sel_s[PB_X];
                        up_y   <= cur_sel_s[PB_Y];
                        up_u   <= cur_sel_s[PB_SP] & ~us_r;
                        up_s   <= cur_sel_s[PB_SP] & us_r;
                        up_pc  <= cur_sel_s[PB_PC];
                        if (nxt_any_s) begin
                            state_r <= nxt_is16_s ? ST_RDHI : ST_RDLO;
                            addr    <= sp_inc_s;
                        end else begin
                            state_r <= ST_DONE;
                            rd      <= 1'b0;
                            done    <= 1'b1;
                            up_sp   <= 1'b1;
                            nx_sp   <= sp_inc_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    rd      <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtkcpu_pulseq.sv
// Scoreboard bench for jtkcpu_pulseq: stimulus queues expected strobes, reads
// and level checks; a negedge monitor pops and compares them.
module tb_jtkcpu_pulseq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  postbyte = 8'h00;
    logic        us_sel = 1'b0;
    logic        rti = 1'b0;
    logic [15:0] sp_in = 16'h0000;
    logic        mem_ok = 1'b1;
    logic [15:0] addr;
    logic        rd;
    logic [7:0]  din;
    logic        busy;
    logic [15:0] data;
    logic        up_cc, up_a, up_b, up_dp, up_x, up_y, up_u, up_s, up_pc;
    logic [15:0] nx_sp;
    logic        up_sp;
    logic        done;

    logic [7:0]  mem [0:65535];
    logic [8:0]  stb_s;
    logic [60:0] outs_s;

    localparam logic [8:0] S_NO = 9'h000, S_CC = 9'h001, S_A = 9'h002, S_B = 9'h004,
                           S_DP = 9'h008, S_X = 9'h010, S_Y = 9'h020, S_U = 9'h040,
                           S_S = 9'h080, S_PC = 9'h100;

    typedef struct {
        logic [8:0]  stb;
        logic [15:0] data;
        logic        fin;
        logic [15:0] nx;
        int          cyc;
    } ev_t;

    typedef struct {
        int cyc;
        int kind;
    } lvl_t;

    ev_t         exp_q[$];
    logic [15:0] addr_q[$];
    lvl_t        lvl_q[$];

    int cyc = 0;
    int t0 = 0;
    int tests = 0;
    int fails = 0;
    int to_events = 0;
    int to_seen = 0;

    assign din    = mem[addr];
    assign stb_s  = {up_pc, up_s, up_u, up_y, up_x, up_dp, up_b, up_a, up_cc};
    assign outs_s = {addr, rd, busy, data, stb_s, nx_sp, up_sp, done};

    jtkcpu_pulseq dut (
        .clk(clk), .rst(rst), .start(start), .postbyte(postbyte), .us_sel(us_sel),
        .rti(rti), .sp_in(sp_in), .addr(addr), .rd(rd), .din(din), .mem_ok(mem_ok),
        .busy(busy), .data(data), .up_cc(up_cc), .up_a(up_a), .up_b(up_b),
        .up_dp(up_dp), .up_x(up_x), .up_y(up_y), .up_u(up_u), .up_s(up_s),
        .up_pc(up_pc), .nx_sp(nx_sp), .up_sp(up_sp), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: timeouts, level checks, read addresses and output events
    always @(negedge clk) begin
        ev_t  e;
        lvl_t l;
        if (to_events != to_seen) begin
            to_seen = to_events;
            tests++;
            fails++;
            $display("FAIL timeout: %0d events and %0d reads still pending, want 0",
                     exp_q.size(), addr_q.size());
            exp_q.delete();
            addr_q.delete();
        end
        while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
            l = lvl_q.pop_front();
            tests++;
            if (l.kind == 0 && outs_s != 61'd0) begin
                fails++;
                $display("FAIL rst_outs @%0d: outputs=%h, want all zero", cyc, outs_s);
            end else if (l.kind == 1 && busy !== 1'b1) begin
                fails++;
                $display("FAIL busy @%0d: busy=%b, want 1", cyc, busy);
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL ev_missing: nothing seen by cycle %0d, want stb=%h data=%h fin=%b at %0d",
                     cyc, e.stb, e.data, e.fin, e.cyc);
        end
        if (rd) begin
            tests++;
            if (addr_q.size() == 0) begin
                fails++;
                $display("FAIL rd_extra @%0d: read at %h, want no read", cyc, addr);
            end else begin
                if (addr !== addr_q[0]) begin
                    fails++;
                    $display("FAIL rd_addr @%0d: addr=%h, want %h", cyc, addr, addr_q[0]);
                end
                if (mem_ok) void'(addr_q.pop_front());
            end
        end
        if (stb_s != 9'd0 || up_sp || done) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL ev_extra @%0d: stb=%h data=%h up_sp=%b done=%b, want none",
                         cyc, stb_s, data, up_sp, done);
            end else begin
                e = exp_q.pop_front();
                if (stb_s !== e.stb || up_sp !== e.fin || done !== e.fin || cyc != e.cyc ||
                    (e.stb != 9'd0 && data !== e.data) || (e.fin && nx_sp !== e.nx)) begin
                    fails++;
                    $display("FAIL ev @%0d: stb=%h data=%h up_sp=%b done=%b nx=%h, want stb=%h data=%h fin=%b nx=%h at %0d",
                             cyc, stb_s, data, up_sp, done, nx_sp, e.stb, e.data, e.fin, e.nx, e.cyc);
                end
            end
        end
    end

    function automatic void ev(input logic [8:0] stb, input logic [15:0] d,
                               input logic fin, input logic [15:0] nx, input int rel);
        ev_t e;
        e.stb  = stb;
        e.data = d;
        e.fin  = fin;
        e.nx   = nx;
        e.cyc  = t0 + rel;
        exp_q.push_back(e);
    endfunction

    function automatic void rdq(input logic [15:0] a);
        addr_q.push_back(a);
    endfunction

    function automatic void lvl(input int rel, input int kind);
        lvl_t l;
        l.cyc  = t0 + rel;
        l.kind = kind;
        lvl_q.push_back(l);
    endfunction

    task automatic kick(input logic [7:0] pb, input logic r, input logic us, input logic [15:0] sp);
        @(posedge clk);
        #1;
        postbyte = pb;
        rti      = r;
        us_sel   = us;
        sp_in    = sp;
        start    = 1'b1;
        t0       = cyc;
    endtask

    task automatic wait_done(input int budget, input int st_at, input int st_len);
        bit ok;
        ok = 1'b0;
        lvl(1, 1);
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            start  = 1'b0;
            mem_ok = !(k >= st_at && k < st_at + st_len);
            if (exp_q.size() == 0 && addr_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        mem_ok = 1'b1;
        if (!ok) begin
            to_events++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lvl(2, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // A then B
        mem[16'h1000] = 8'h12; mem[16'h1001] = 8'h34;
        kick(8'h06, 1'b0, 1'b0, 16'h1000);
        rdq(16'h1000); rdq(16'h1001);
        ev(S_A, 16'h0012, 1'b0, 16'h0000, 2);
        ev(S_B, 16'h0034, 1'b1, 16'h1002, 3);
        wait_done(20, 0, 0);

        // X, big-endian
        mem[16'h2000] = 8'hAB; mem[16'h2001] = 8'hCD;
        kick(8'h10, 1'b0, 1'b0, 16'h2000);
        rdq(16'h2000); rdq(16'h2001);
        ev(S_X, 16'hABCD, 1'b1, 16'h2002, 3);
        wait_done(20, 0, 0);

        // RTI with E clear: CC then PC
        mem[16'h3000] = 8'h00; mem[16'h3001] = 8'h12; mem[16'h3002] = 8'h34;
        kick(8'h00, 1'b1, 1'b0, 16'h3000);
        for (int i = 0; i < 3; i++) rdq(16'h3000 + 16'(i));
        ev(S_CC, 16'h0000, 1'b0, 16'h0000, 2);
        ev(S_PC, 16'h1234, 1'b1, 16'h3003, 4);
        wait_done(20, 0, 0);

        // RTI with E set: full frame of 12 bytes
        mem[16'h3000] = 8'h80;
        for (int i = 1; i < 12; i++) mem[16'h3000 + 16'(i)] = 8'(i * 17);
        kick(8'h55, 1'b1, 1'b0, 16'h3000);
        for (int i = 0; i < 12; i++) rdq(16'h3000 + 16'(i));
        ev(S_CC, 16'h0080, 1'b0, 16'h0000, 2);
        ev(S_A,  16'h0011, 1'b0, 16'h0000, 3);
        ev(S_B,  16'h0022, 1'b0, 16'h0000, 4);
        ev(S_DP, 16'h0033, 1'b0, 16'h0000, 5);
        ev(S_X,  16'h4455, 1'b0, 16'h0000, 7);
        ev(S_Y,  16'h6677, 1'b0, 16'h0000, 9);
        ev(S_U,  16'h8899, 1'b0, 16'h0000, 11);
        ev(S_PC, 16'hAABB, 1'b1, 16'h300C, 13);
        wait_done(40, 0, 0);

        // Pointer wrap at the top of memory
        mem[16'hFFFF] = 8'hDE; mem[16'h0000] = 8'hAD;
        kick(8'h80, 1'b0, 1'b0, 16'hFFFF);
        rdq(16'hFFFF); rdq(16'h0000);
        ev(S_PC, 16'hDEAD, 1'b1, 16'h0001, 3);
        wait_done(20, 0, 0);

        // Other stack pointer pulled from S gives U
        mem[16'h4000] = 8'h56; mem[16'h4001] = 8'h78;
        kick(8'h40, 1'b0, 1'b0, 16'h4000);
        rdq(16'h4000); rdq(16'h4001);
        ev(S_U, 16'h5678, 1'b1, 16'h4002, 3);
        wait_done(20, 0, 0);

        // Pulled from U gives S, with two stall cycles on the low byte
        kick(8'h40, 1'b0, 1'b1, 16'h4000);
        rdq(16'h4000); rdq(16'h4001);
        ev(S_S, 16'h5678, 1'b1, 16'h4002, 5);
        wait_done(20, 2, 2);

        // Reset in the middle of a full pull
        mem[16'h5000] = 8'h9C; mem[16'h5001] = 8'h3F; mem[16'h5002] = 8'h77;
        kick(8'hFF, 1'b0, 1'b0, 16'h5000);
        rdq(16'h5000); rdq(16'h5001);
        ev(S_CC, 16'h009C, 1'b0, 16'h0000, 2);
        lvl(3, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Empty mask straight to completion
        kick(8'h00, 1'b0, 1'b0, 16'h6000);
        ev(S_NO, 16'h0000, 1'b1, 16'h6000, 1);
        wait_done(20, 0, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
